wishbone_test_slave_32_32: RTL and testbench

Parameterised Wishbone B4 responder for the Wishbone test system: the slave-side counterpart of the test master. It sits on an interconnect slave port and answers classic and incrementing-burst cycles from a local word memory. It supports programmable wait states, byte-lane writes, out-of-window error responses and read/write transaction counters. Benches use it as a scoreboard-friendly endpoint with controllable latency.

---
 rtl/wishbone_test_slave_32_32.sv | 137 +++++++++++++
 tb/tb_wishbone_test_slave_32_32.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_test_slave_32_32.sv
// Wishbone B4 test slave: answers classic and incrementing-burst cycles from a
// local word memory. Supports programmable wait states before the first beat,
// byte-lane writes, and read/write beat counters.
// Optional feature macro: WISHBONE_TEST_SLAVE_ERR_EN. When it is defined,
// beats outside the address window complete with ERR. When it is undefined,
// such beats alias into the memory and are ACKed.
module wishbone_test_slave_32_32 #(
  parameter int MEM_ADDR_BITS = 8,
  parameter int WAIT_BITS     = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          io_addr_base,
  input  logic [WAIT_BITS-1:0] io_wait,
  input  logic [31:0]          io_s_ADR,
  input  logic [31:0]          io_s_DAT_W,
  input  logic [3:0]           io_s_SEL,
  input  logic                 io_s_CYC,
  input  logic                 io_s_STB,
  input  logic                 io_s_WE,
  input  logic [2:0]           io_s_CTI,
  input  logic [1:0]           io_s_BTE,
  input  logic                 io_s_TGA,
  input  logic                 io_s_TGC,
  input  logic                 io_s_TGD_W,
  output logic [31:0]          io_s_DAT_R,
  output logic                 io_s_TGD_R,
  output logic                 io_s_ACK,
  output logic                 io_s_ERR,
  output logic [15:0]          io_rd_count,
  output logic [15:0]          io_wr_count
);

  localparam int DEPTH = 1 << MEM_ADDR_BITS;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, BURST} state_t;

  state_t                   state;
  logic [WAIT_BITS-1:0]     wcnt;
  logic [31:0]              mem [DEPTH];

  logic [31:0]              off;
  logic [MEM_ADDR_BITS-1:0] idx;
  logic                     req;
  logic                     ok;
  logic                     take;
  logic                     cti_burst;
  logic                     unused_ok;

  assign off       = io_s_ADR - io_addr_base;
  assign idx       = off[MEM_ADDR_BITS+1:2];
  assign req       = io_s_CYC & io_s_STB;
  // Only 010 continues a burst; 111, 000 and the reserved codes all end it.
  assign cti_burst = (io_s_CTI == 3'b010);
  assign io_s_TGD_R = 1'b0;

`ifdef WISHBONE_TEST_SLAVE_ERR_EN
  assign ok = (io_s_ADR >= io_addr_base) && (off[31:MEM_ADDR_BITS+2] == '0);
  assign unused_ok = ^{io_s_TGA, io_s_TGC, io_s_TGD_W, io_s_BTE, off[1:0]};
`else
  // Every beat lands somewhere: out-of-window addresses alias by offset bits.
  assign ok = 1'b1;
  assign unused_ok = ^{io_s_TGA, io_s_TGC, io_s_TGD_W, io_s_BTE, off[1:0],
                       off[31:MEM_ADDR_BITS+2]};
  assign io_s_ERR = 1'b0;
`endif

  // Decide whether a beat completes on this edge (response visible next cycle).
  always_comb begin
    take = 1'b0;
    unique case (state)
      IDLE:    take = req && (io_wait == '0);
      WAIT:    take = req && (wcnt == WAIT_BITS'(1));
      BURST:   take = req;
      default: take = 1'b0;
    endcase
  end

  // Byte-lane memory writes; a reset edge suppresses any pending commit.
  always_ff @(posedge clock) begin
    if (!reset && take && ok && io_s_WE) begin
      for (int b = 0; b < 4; b++) begin
        if (io_s_SEL[b]) mem[idx][8*b +: 8] <= io_s_DAT_W[8*b +: 8];
      end
    end
  end

  // Cycle FSM with registered ACK/ERR, read data and beat counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      wcnt        <= '0;
      io_s_ACK    <= 1'b0;
      io_s_DAT_R  <= '0;
      io_rd_count <= '0;
      io_wr_count <= '0;
`ifdef WISHBONE_TEST_SLAVE_ERR_EN
      io_s_ERR    <= 1'b0;
`endif
    end else begin
      io_s_ACK   <= take && ok;
      io_s_DAT_R <= (take && ok && !io_s_WE) ? mem[idx] : '0;
`ifdef WISHBONE_TEST_SLAVE_ERR_EN
      io_s_ERR   <= take && !ok;
`endif
      if (take && ok && io_s_WE)  io_wr_count <= io_wr_count + 16'd1;
      if (take && ok && !io_s_WE) io_rd_count <= io_rd_count + 16'd1;

      unique case (state)
        IDLE: begin
          if (req) begin
            if (io_wait == '0) begin
              state <= cti_burst ? BURST : RESP;
            end else begin
              wcnt  <= io_wait;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!io_s_CYC)                  state <= IDLE;
          else if (take)                  state <= cti_burst ? BURST : RESP;
          else if (wcnt != WAIT_BITS'(1)) wcnt  <= wcnt - WAIT_BITS'(1);
        end
        // Response cycle of a final beat: inputs are ignored here, which
        // guarantees a gap before the next classic cycle is accepted.
        RESP: state <= IDLE;
        BURST: begin
          if (!io_s_CYC) state <= IDLE;
          else if (take) state <= cti_burst ? BURST : RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_test_slave_32_32.sv
// Self-checking bench for wishbone_test_slave_32_32: directed vector table,
// hand-written burst/abort/reset sequences, and randomized classic traffic
// checked against a word-array reference model.
module tb_wishbone_test_slave_32_32;
  localparam int          MAB   = 8;
  localparam int          WB    = 4;
  localparam int          WORDS = 1 << MAB;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic          clock = 1'b0;
  logic          reset;
  logic [31:0]   addr_base;
  logic [WB-1:0] wt;
  logic [31:0]   adr, dat_w, dat_r;
  logic [3:0]    sel;
  logic          cyc, stb, we, tga, tgc, tgd_w, tgd_r, ack, err;
  logic [2:0]    cti;
  logic [1:0]    bte;
  logic [15:0]   rd_cnt, wr_cnt;

  wishbone_test_slave_32_32 #(.MEM_ADDR_BITS(MAB), .WAIT_BITS(WB)) dut (
    .clock(clock), .reset(reset), .io_addr_base(addr_base), .io_wait(wt),
    .io_s_ADR(adr), .io_s_DAT_W(dat_w), .io_s_SEL(sel), .io_s_CYC(cyc),
    .io_s_STB(stb), .io_s_WE(we), .io_s_CTI(cti), .io_s_BTE(bte),
    .io_s_TGA(tga), .io_s_TGC(tgc), .io_s_TGD_W(tgd_w), .io_s_DAT_R(dat_r),
    .io_s_TGD_R(tgd_r), .io_s_ACK(ack), .io_s_ERR(err),
    .io_rd_count(rd_cnt), .io_wr_count(wr_cnt));

  always #5 clock = ~clock;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: plain word array plus beat counters.
  logic [31:0] ref_mem [WORDS];
  int exp_rd_cnt = 0, exp_wr_cnt = 0;

  function automatic bit in_win(logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'(4 * WORDS));
  endfunction

  function automatic int widx(logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return int'((o >> 2) % 32'(WORDS));
  endfunction

  task automatic model_beat(input bit m_we, input logic [31:0] a, d, input logic [3:0] s,
                            output bit x_err, output logic [31:0] x_rd);
    int i;
    x_err = 1'b0;
    x_rd  = '0;
`ifdef WISHBONE_TEST_SLAVE_ERR_EN
    if (!in_win(a)) begin
      x_err = 1'b1;
      return;
    end
`endif
    i = widx(a);
    if (m_we) begin
      for (int b = 0; b < 4; b++) if (s[b]) ref_mem[i][8*b +: 8] = d[8*b +: 8];
      exp_wr_cnt = (exp_wr_cnt + 1) % 65536;
    end else begin
      x_rd = ref_mem[i];
      exp_rd_cnt = (exp_rd_cnt + 1) % 65536;
    end
  endtask

  // One classic cycle; lat = cycles from first sample to response, -1 on timeout.
  task automatic bus_cycle(input bit b_we, input logic [31:0] a, d, input logic [3:0] s,
                           input int w, output int lat, output bit got_err,
                           output logic [31:0] rd);
    lat = -1; got_err = 1'b0; rd = '0;
    @(negedge clock);
    wt = WB'(w); adr = a; dat_w = d; sel = s; we = b_we; cti = 3'b000;
    cyc = 1'b1; stb = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (ack || err) begin
        lat = k; got_err = err; rd = dat_r;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clock);
    chk("resp_one_cycle", {ack, err}, 2'b00);
    chk("dat_r_cleared", dat_r, 32'h0);
  endtask

  task automatic run_beat(input string nm, input bit b_we, input logic [31:0] a, d,
                          input logic [3:0] s, input int w,
                          output logic [31:0] rd, output bit ge);
    bit xe; logic [31:0] xr; int lat;
    model_beat(b_we, a, d, s, xe, xr);
    bus_cycle(b_we, a, d, s, w, lat, ge, rd);
    chk({nm, "_latency"}, 64'(lat), 64'(w + 1));
    chk({nm, "_err"}, ge, xe);
    chk({nm, "_rdata"}, rd, xr);
    chk({nm, "_rd_count"}, rd_cnt, 64'(exp_rd_cnt));
    chk({nm, "_wr_count"}, wr_cnt, 64'(exp_wr_cnt));
  endtask

  // Incrementing burst of n beats starting at 'start'; write data from bdata.
  logic [31:0] bdata [WORDS];
  logic [31:0] bres  [WORDS];

  task automatic burst(input bit b_we, input logic [31:0] start, input int n);
    bit xe; logic [31:0] xr;
    @(negedge clock);
    wt = '0; cyc = 1'b1; stb = 1'b1; we = b_we; sel = 4'hF;
    adr = start; dat_w = bdata[0]; cti = (n == 1) ? 3'b111 : 3'b010;
    for (int i = 0; i < n; i++) begin
      model_beat(b_we, start + 32'(4 * i), bdata[i], 4'hF, xe, xr);
      @(negedge clock);
      bres[i] = dat_r;
      chk("burst_ack", ack, 1'b1);
      chk("burst_rdata", dat_r, xr);
      if (i < n - 1) begin
        adr = start + 32'(4 * (i + 1)); dat_w = bdata[i + 1];
        cti = (i + 1 == n - 1) ? 3'b111 : 3'b010;
      end else begin
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
      end
    end
    @(negedge clock);
    chk("burst_end_no_ack", ack, 1'b0);
    chk("burst_rd_count", rd_cnt, 64'(exp_rd_cnt));
    chk("burst_wr_count", wr_cnt, 64'(exp_wr_cnt));
  endtask

  typedef struct {
    bit          we;
    logic [31:0] off;
    logic [31:0] data;
    logic [3:0]  sel;
    int          w;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt [11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, a;
    bit ge, any;
    int r;

    vt[0]  = '{1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 0, 32'h0};
    vt[1]  = '{1'b0, 32'h010, 32'h0,        4'hF, 0, 32'hDEADBEEF};
    vt[2]  = '{1'b0, 32'h010, 32'h0,        4'hF, 3, 32'hDEADBEEF};
    vt[3]  = '{1'b1, 32'h020, 32'hAABBCCDD, 4'hF, 0, 32'h0};
    vt[4]  = '{1'b1, 32'h020, 32'h11223344, 4'h5, 2, 32'h0};
    vt[5]  = '{1'b0, 32'h020, 32'h0,        4'hF, 1, 32'hAA22CC44};
    vt[6]  = '{1'b1, 32'h024, 32'hCAFEF00D, 4'hF, 0, 32'h0};
    vt[7]  = '{1'b1, 32'h024, 32'h12345678, 4'h0, 0, 32'h0};
    vt[8]  = '{1'b0, 32'h024, 32'h0,        4'hF, 0, 32'hCAFEF00D};
    vt[9]  = '{1'b1, 32'h3FC, 32'h0BADC0DE, 4'hF, 1, 32'h0};
    vt[10] = '{1'b0, 32'h3FC, 32'h0,        4'hF, 0, 32'h0BADC0DE};

    for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
    reset = 1'b1; addr_base = BASE; wt = '0; adr = '0; dat_w = '0; sel = '0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = '0; bte = '0;
    tga = 1'b0; tgc = 1'b0; tgd_w = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("reset_ack", ack, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_dat_r", dat_r, 32'h0);
    chk("reset_tgd_r", tgd_r, 1'b0);
    chk("reset_rd_count", rd_cnt, 16'h0);
    chk("reset_wr_count", wr_cnt, 16'h0);

    // Directed table: write/read, wait states, byte lanes, SEL=0, last word.
    for (int i = 0; i < 11; i++) begin
      run_beat($sformatf("vec%0d", i), vt[i].we, BASE + vt[i].off, vt[i].data,
               vt[i].sel, vt[i].w, rd, ge);
      if (!vt[i].we) chk($sformatf("vec%0d_const", i), rd, vt[i].exp_rd);
    end
    chk("table_rd_count", rd_cnt, 16'd5);
    chk("table_wr_count", wr_cnt, 16'd6);

    // Back-to-back: request held while slave returns to IDLE is taken next cycle.
    @(negedge clock);
    wt = '0; adr = BASE + 32'h10; we = 1'b0; sel = 4'hF; cti = '0; cyc = 1'b1; stb = 1'b1;
    @(negedge clock);
    chk("b2b_first_ack", ack, 1'b1);
    chk("b2b_first_data", dat_r, 32'hDEADBEEF);
    adr = BASE + 32'h20;
    @(negedge clock);
    chk("b2b_gap", ack, 1'b0);
    @(negedge clock);
    chk("b2b_second_ack", ack, 1'b1);
    chk("b2b_second_data", dat_r, 32'hAA22CC44);
    cyc = 1'b0; stb = 1'b0;
    exp_rd_cnt += 2;
    @(negedge clock);
    chk("b2b_rd_count", rd_cnt, 64'(exp_rd_cnt));

    // Burst write 1..4 then 4-beat burst read.
    for (int i = 0; i < 4; i++) bdata[i] = 32'(i + 1);
    burst(1'b1, BASE, 4);
    burst(1'b0, BASE, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("burst_read_%0d", i), bres[i], 32'(i + 1));
    run_beat("after_burst", 1'b0, BASE + 32'h4, 32'h0, 4'hF, 0, rd, ge);

    // Window boundaries: one word past the end, one word below the base.
    run_beat("oob_hi", 1'b0, BASE + 32'(4 * WORDS), 32'h0, 4'hF, 0, rd, ge);
`ifdef WISHBONE_TEST_SLAVE_ERR_EN
    chk("oob_hi_const_err", ge, 1'b1);
`else
    chk("oob_hi_const_data", rd, 32'h1);
`endif
    run_beat("oob_lo", 1'b0, BASE - 32'h4, 32'h0, 4'hF, 0, rd, ge);
`ifdef WISHBONE_TEST_SLAVE_ERR_EN
    chk("oob_lo_const_err", ge, 1'b1);
`else
    chk("oob_lo_const_data", rd, 32'h0BADC0DE);
`endif

    // CYC dropped during wait states: no response, no write, no count.
    @(negedge clock);
    wt = WB'(5); adr = BASE + 32'h10; dat_w = 32'h55555555; sel = 4'hF; we = 1'b1;
    cti = '0; cyc = 1'b1; stb = 1'b1;
    repeat (2) @(negedge clock);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    any = 1'b0;
    repeat (8) begin @(negedge clock); any |= ack | err; end
    chk("abort_no_ack", any, 1'b0);
    chk("abort_rd_count", rd_cnt, 64'(exp_rd_cnt));
    chk("abort_wr_count", wr_cnt, 64'(exp_wr_cnt));

    // Reset during a wait period: no response, no write, counters cleared.
    @(negedge clock);
    wt = WB'(5); adr = BASE + 32'h10; dat_w = 32'h77777777; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_ack", {ack, err}, 2'b00);
    reset = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    exp_rd_cnt = 0; exp_wr_cnt = 0;
    any = 1'b0;
    repeat (8) begin @(negedge clock); any |= ack | err; end
    chk("rst_mid_no_ack", any, 1'b0);
    chk("rst_mid_rd_count", rd_cnt, 16'h0);
    chk("rst_mid_wr_count", wr_cnt, 16'h0);
    run_beat("mem_unchanged", 1'b0, BASE + 32'h10, 32'h0, 4'hF, 0, rd, ge);
    chk("mem_unchanged_const", rd, 32'hDEADBEEF);

    // Randomized traffic against the reference model.
    for (int i = 0; i < WORDS; i++) bdata[i] = $urandom;
    burst(1'b1, BASE, WORDS);
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 15);
      if (r == 0)      a = BASE + 32'(4 * WORDS) + 32'(4 * $urandom_range(0, 63));
      else if (r == 1) a = BASE - 32'(4 * $urandom_range(1, 64));
      else             a = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
      a = a | 32'($urandom_range(0, 3));
      run_beat($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), a, $urandom,
               4'($urandom_range(0, 15)), $urandom_range(0, 3), rd, ge);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
